// File: rtl/multi_timer.sv
// Multi-channel countdown timer: CHANNELS independent IDLE/RUN/DONE timers
// that decrement on a shared tick strobe, with one-shot or periodic reload.

// One countdown channel.
module multi_timer_ch #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             cancel,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] reload_val;
  logic             mode;

  // Channel state update; priority is reset > start > cancel > tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      reload_val <= '0;
      mode       <= 1'b0;
      expire     <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (start) begin
        reload_val <= load_value;
        mode       <= auto_reload;
        cnt        <= load_value;
        if (load_value != '0) begin
          state <= RUN;
        end else begin
          // A zero load expires immediately and never reloads.
          state  <= DONE;
          expire <= 1'b1;
        end
      end else if (cancel) begin
        if (state != IDLE) begin
          state <= IDLE;
          cnt   <= '0;
        end
      end else if (state == RUN && tick && !pause) begin
        if (cnt == WIDTH'(1)) begin
          expire <= 1'b1;
          if (mode) begin
            cnt <= reload_val;
          end else begin
            cnt   <= '0;
            state <= DONE;
          end
        end else begin
          // cnt is never 0 in RUN, so this cannot wrap.
          cnt <= cnt - WIDTH'(1);
        end
      end
    end
  end

  assign count = cnt;
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
endmodule

// Top: array of independent channels sharing clock, reset and tick.
module multi_timer #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic [CHANNELS-1:0]       pause,
  input  logic [CHANNELS-1:0]       auto_reload,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       expire
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    multi_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .start       (start[i]),
      .cancel      (cancel[i]),
      .pause       (pause[i]),
      .auto_reload (auto_reload[i]),
      .load_value  (load_value[i*WIDTH +: WIDTH]),
      .count       (count[i*WIDTH +: WIDTH]),
      .busy        (busy[i]),
      .done        (done[i]),
      .expire      (expire[i])
    );
  end
endmodule

// File: tb/tb_multi_timer.sv
// Directed scoreboard bench for multi_timer.
module tb_multi_timer;
  localparam int W = 10;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           tick = 1'b0;
  logic [C-1:0]   start = '0, cancel = '0, pause = '0, auto_reload = '0;
  logic [C*W-1:0] load_value = '0;
  logic [C*W-1:0] count;
  logic [C-1:0]   busy, done, expire;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    kind;   // 0 count, 1 busy, 2 done, 3 expire
    int    ch;
    int    val;
  } exp_t;
  exp_t sb[$];

  multi_timer #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .cancel(cancel),
    .pause(pause), .auto_reload(auto_reload), .load_value(load_value),
    .count(count), .busy(busy), .done(done), .expire(expire)
  );

  always #5 clk = ~clk;

  function automatic int obs(int kind, int ch);
    case (kind)
      0:       return int'(count[ch*W +: W]);
      1:       return int'(busy[ch]);
      2:       return int'(done[ch]);
      default: return int'(expire[ch]);
    endcase
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic set_load(int ch, int v);
    load_value[ch*W +: W] = W'(v);
  endtask

  task automatic push_ch(string tag, int ch, int c, int b, int d, int e);
    sb.push_back('{tag, 0, ch, c});
    sb.push_back('{tag, 1, ch, b});
    sb.push_back('{tag, 2, ch, d});
    sb.push_back('{tag, 3, ch, e});
  endtask

  task automatic drain();
    exp_t x;
    int   o;
    string nm;
    while (sb.size() > 0) begin
      x  = sb.pop_front();
      o  = obs(x.kind, x.ch);
      nm = (x.kind == 0) ? "count" : (x.kind == 1) ? "busy" :
           (x.kind == 2) ? "done" : "expire";
      n_assert++;
      assert (o === x.val) else begin
        n_fail++;
        $error("FAIL %s ch%0d %s: observed %0d expected %0d", x.tag, x.ch, nm, o, x.val);
      end
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    for (int i = 0; i < C; i++) push_ch("reset", i, 0, 0, 0, 0);
    drain();
    reset = 1'b1;
    cyc(1);

    // Ch0 one-shot load 3, tick every 4 cycles
    set_load(0, 3); start[0] = 1'b1; cyc(1); start = '0;
    push_ch("os_start", 0, 3, 1, 0, 0); drain();
    for (int k = 1; k <= 3; k++) begin
      cyc(3);
      tick_once();
      push_ch("os_tick", 0, 3 - k, (k < 3) ? 1 : 0, (k == 3) ? 1 : 0, (k == 3) ? 1 : 0);
      drain();
    end
    cyc(1);
    push_ch("os_hold", 0, 0, 0, 1, 0); drain();
    tick_once();
    push_ch("os_tick_done", 0, 0, 0, 1, 0); drain();
    cancel[0] = 1'b1; cyc(1); cancel = '0;
    push_ch("os_cancel", 0, 0, 0, 0, 0); drain();

    // Ch1 periodic load 2, six ticks
    set_load(1, 2); auto_reload[1] = 1'b1; start[1] = 1'b1; cyc(1);
    start = '0; auto_reload = '0;
    push_ch("per_start", 1, 2, 1, 0, 0); drain();
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      tick_once();
      push_ch("per_tick", 1, (k % 2 == 1) ? 1 : 2, 1, 0, (k % 2 == 0) ? 1 : 0);
      drain();
    end
    cyc(1);
    push_ch("per_after", 1, 2, 1, 0, 0); drain();
    cancel[1] = 1'b1; cyc(1); cancel = '0;
    push_ch("per_cancel", 1, 0, 0, 0, 0); drain();

    // Ch2 load 5 with a pause across 3 ticks
    set_load(2, 5); start[2] = 1'b1; cyc(1); start = '0;
    tick_once(); tick_once();
    push_ch("pz_pre", 2, 3, 1, 0, 0); drain();
    pause[2] = 1'b1;
    for (int k = 0; k < 3; k++) tick_once();
    push_ch("pz_hold", 2, 3, 1, 0, 0); drain();
    pause = '0;
    tick_once(); tick_once();
    push_ch("pz_four", 2, 1, 1, 0, 0); drain();
    tick_once();
    push_ch("pz_exp", 2, 0, 0, 1, 1); drain();
    cancel[2] = 1'b1; cyc(1); cancel = '0;

    // Ch3 load 0 periodic
    set_load(3, 0); auto_reload[3] = 1'b1; start[3] = 1'b1; cyc(1);
    start = '0; auto_reload = '0;
    push_ch("zero_start", 3, 0, 0, 1, 1); drain();
    cyc(1);
    push_ch("zero_hold", 3, 0, 0, 1, 0); drain();
    tick_once();
    push_ch("zero_tick", 3, 0, 0, 1, 0); drain();
    cancel[3] = 1'b1; cyc(1); cancel = '0;

    // Ch0 restart with start+tick+cancel, then reset mid-run
    set_load(0, 6); start[0] = 1'b1; cyc(1); start = '0;
    tick_once(); tick_once();
    push_ch("rs_four", 0, 4, 1, 0, 0); drain();
    set_load(0, 7); start[0] = 1'b1; cancel[0] = 1'b1; tick = 1'b1;
    cyc(1);
    start = '0; cancel = '0; tick = 1'b0;
    push_ch("rs_restart", 0, 7, 1, 0, 0); drain();
    tick_once();
    push_ch("rs_count", 0, 6, 1, 0, 0); drain();
    reset = 1'b0; start[0] = 1'b1; tick = 1'b1;
    cyc(1);
    push_ch("rs_reset", 0, 0, 0, 0, 0); drain();
    reset = 1'b1; start = '0; tick = 1'b0;
    cyc(1);
    push_ch("rs_release", 0, 0, 0, 0, 0); drain();
    tick_once();
    push_ch("rs_idle_tick", 0, 0, 0, 0, 0); drain();

    // All channels load 1, one tick
    for (int i = 0; i < C; i++) set_load(i, 1);
    start = '1; cyc(1); start = '0;
    tick_once();
    for (int i = 0; i < C; i++) push_ch("all_exp", i, 0, 0, 1, 1);
    drain();
    cancel = '1; cyc(1); cancel = '0;

    // Full-scale 1023, mode/load changed mid-run must not matter
    set_load(0, 1023); start[0] = 1'b1; cyc(1); start = '0;
    auto_reload[0] = 1'b1; set_load(0, 5);
    tick = 1'b1; cyc(1022); tick = 1'b0;
    push_ch("max_1022", 0, 1, 1, 0, 0); drain();
    tick_once();
    push_ch("max_1023", 0, 0, 0, 1, 1); drain();
    cyc(1);
    push_ch("max_after", 0, 0, 0, 1, 0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
